mem_bus_arbiter: RTL

- Shares one memory port between instruction fetch (IF) and load/store (LS) requesters.
- Sits between IFU/MEM and the memory model or bus bridge; replaces the separate fetch and data DPI paths with a single sequenced port.
- Handles one transaction at a time: arbitrate, issue address, wait for response, return data.
- Provides anti-starvation for IF, a timeout, and a fetch-kill on redirect.

---
 rtl/npc_bus_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/npc_bus_pkg.sv
// Shared types for the single-port memory arbiter.
// Pure declarations: no latency, no flow control.
package npc_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int WMASK_W = 8;
endpackage

// File: rtl/mem_arb_pick.sv
// IF/LS pick rule with IF anti-starvation counter; combinational grant.
// Backpressure: a losing requester simply stays pending until a later grant_en.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant_en,
    output logic gnt_if,
    output logic gnt_ls
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          if_wins;

    always_comb begin
        if_wins      = if_req && (!ls_req || (starve_cnt_q == CW'(STARVE_MAX)));
        gnt_if       = grant_en && if_wins;
        gnt_ls       = grant_en && ls_req && !if_wins;
        starve_cnt_d = starve_cnt_q;
        if (gnt_if) begin
            starve_cnt_d = '0;
        end else if (gnt_ls && if_req && (starve_cnt_q != CW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Min latency grant->rvalid 3 cycles; mem_req_valid held until mem_req_ready, timeout aborts.
module mem_bus_arbiter
    import npc_bus_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [WIDTH-1:0]   if_addr,
    input  logic               if_kill,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [31:0]        if_rdata,
    output logic               if_rerr,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [WIDTH-1:0]   ls_addr,
    input  logic [WIDTH-1:0]   ls_wdata,
    input  logic [WMASK_W-1:0] ls_wmask,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [WIDTH-1:0]   ls_rdata,
    output logic               ls_rerr,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_resp_valid,
    input  logic [WIDTH-1:0]   mem_rdata
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [WMASK_W-1:0] wmask_q, wmask_d;
    logic               we_q, we_d, kill_q, kill_d, err_q, err_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               grant_en, gnt_if, gnt_ls, tmo_hit;

    // Gating with rst keeps the combinational grants quiet while held in reset.
    assign grant_en = (state_q == IDLE) && rst;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .grant_en (grant_en),
        .gnt_if   (gnt_if),
        .gnt_ls   (gnt_ls)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        kill_d  = kill_q;
        err_d   = err_q;
        tmo_hit = (tmo_q + TW'(1)) == TW'(TIMEOUT);

        case (state_q)
            IDLE: begin
                if (gnt_if || gnt_ls) begin
                    state_d = ADDR;
                    owner_d = gnt_if ? OWN_IF : OWN_LS;
                    addr_d  = gnt_if ? if_addr : ls_addr;
                    we_d    = gnt_ls && ls_we;
                    wdata_d = gnt_ls ? ls_wdata : '0;
                    wmask_d = gnt_ls ? ls_wmask : '0;
                    tmo_d   = '0;
                    kill_d  = gnt_if && if_kill;
                    err_d   = 1'b0;
                end
            end
            ADDR: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_req_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tmo_d = tmo_q + TW'(1);
                // A response landing on the last allowed cycle is still taken.
                if (mem_resp_valid) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((owner_q == OWN_IF) && ((state_q == ADDR) || (state_q == DATA)) && if_kill) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
        end
    end

    assign if_gnt        = gnt_if;
    assign ls_gnt        = gnt_ls;
    assign if_rvalid     = (state_q == RESP) && (owner_q == OWN_IF) && !kill_q;
    assign if_rerr       = if_rvalid && err_q;
    assign if_rdata      = addr_q[2] ? rdata_q[32 +: 32] : rdata_q[0 +: 32];
    assign ls_rvalid     = (state_q == RESP) && (owner_q == OWN_LS);
    assign ls_rerr       = ls_rvalid && err_q;
    assign ls_rdata      = rdata_q;
    assign mem_req_valid = (state_q == ADDR);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
endmodule
